// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multiport register file and its bulk-clear engine.
package regfile_pkg;

  typedef enum logic [1:0] {
    RF_IDLE,
    RF_CLEAR,
    RF_DONE
  } rf_clear_state_t;

  function automatic logic rf_index_valid(input int unsigned idx, input int unsigned num_regs);
    return idx < num_regs;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer: sweeps one entry per cycle, then pulses clear_done.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned INDEX_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear_req,
  output logic                   idle,
  output logic                   clear_busy,
  output logic                   clear_done,
  output logic                   clr_en,
  output logic [INDEX_WIDTH-1:0] clr_index
);

  localparam logic [INDEX_WIDTH-1:0] LAST_PTR = INDEX_WIDTH'(NUM_REGS - 1);

  rf_clear_state_t        state_q, state_d;
  logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      RF_IDLE: begin
        if (clear_req) begin
          state_d = RF_CLEAR;
          ptr_d   = '0;
        end
      end
      // Pointer parks on the last entry instead of wrapping.
      RF_CLEAR: begin
        if (ptr_q == LAST_PTR) state_d = RF_DONE;
        else                   ptr_d   = ptr_q + INDEX_WIDTH'(1);
      end
      RF_DONE:  state_d = RF_IDLE;
      default:  state_d = RF_IDLE;
    endcase
    busy_d = (state_d == RF_CLEAR);
    done_d = (state_d == RF_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RF_IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign idle       = (state_q == RF_IDLE);
  assign clear_busy = busy_q;
  assign clear_done = done_q;
  assign clr_en     = (state_q == RF_CLEAR);
  assign clr_index  = ptr_q;

endmodule

// File: rtl/register_file_multiport.sv
// Two-read, one-write register file with write-through bypass, optional zero
// register and a sequential bulk-clear engine.
module register_file_multiport
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned INDEX_WIDTH = $clog2(NUM_REGS),
  parameter bit          ZERO_REG    = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [INDEX_WIDTH-1:0] read_index_a,
  output logic [DATA_WIDTH-1:0]  read_data_a,
  input  logic [INDEX_WIDTH-1:0] read_index_b,
  output logic [DATA_WIDTH-1:0]  read_data_b,
  input  logic [INDEX_WIDTH-1:0] write_index,
  input  logic                   write_enable,
  input  logic [DATA_WIDTH-1:0]  write_data,
  input  logic                   clear_req,
  output logic                   clear_busy,
  output logic                   clear_done
);

  logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]  regs_d [NUM_REGS];
  logic                   idle;
  logic                   clr_en;
  logic [INDEX_WIDTH-1:0] clr_index;
  logic                   wr_ok;

  regfile_clear_fsm #(
    .NUM_REGS   (NUM_REGS),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_clear_fsm (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_req (clear_req),
    .idle      (idle),
    .clear_busy(clear_busy),
    .clear_done(clear_done),
    .clr_en    (clr_en),
    .clr_index (clr_index)
  );

  function automatic logic is_zero_reg(input logic [INDEX_WIDTH-1:0] idx);
    return ZERO_REG && (idx == '0);
  endfunction

  // A write that will commit; the same qualifier gates the bypass path.
  assign wr_ok = idle && write_enable && !is_zero_reg(write_index)
              && rf_index_valid(32'(write_index), NUM_REGS);

  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_ok && (write_index == INDEX_WIDTH'(i))) regs_d[i] = write_data;
      if (clr_en && (clr_index == INDEX_WIDTH'(i)))  regs_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) regs_q <= '{default: '0};
    else          regs_q <= regs_d;
  end

  always_comb begin
    read_data_a = '0;
    read_data_b = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (read_index_a == INDEX_WIDTH'(i)) read_data_a = regs_q[i];
      if (read_index_b == INDEX_WIDTH'(i)) read_data_b = regs_q[i];
    end
    if (is_zero_reg(read_index_a)) read_data_a = '0;
    if (is_zero_reg(read_index_b)) read_data_b = '0;
    if (wr_ok && (write_index == read_index_a)) read_data_a = write_data;
    if (wr_ok && (write_index == read_index_b)) read_data_b = write_data;
  end

endmodule
